// File: rtl/fir_out_unpacker.sv
// Receive-side unpacker: buffers up to two packed FIR result words and streams
// them out one lane per valid/ready transfer. Define FIR_UNPACK_SAT_EN to saturate lanes.
module fir_out_unpacker #(
  parameter int LANES  = 10,
  parameter int LANE_W = 24,
  parameter int OUT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*LANE_W-1:0]   data_in,
  input  logic                      data_en,
  output logic [OUT_W-1:0]          m_data,
  output logic [3:0]                m_lane,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      in_drop,
  output logic                      busy
);

  localparam int         WORD_W    = LANES * LANE_W;
  localparam logic [3:0] LAST_LANE = 4'(LANES - 1);

  logic [WORD_W-1:0] buf_q [2];
  logic [WORD_W-1:0] buf_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [3:0]        lane_q, lane_d;
  logic              drop_q, drop_d;

  logic              handshake;
  logic              pop;
  logic              wr_accept;
  logic [WORD_W-1:0] head_word;
  logic [LANE_W-1:0] head_lanes [LANES];
  logic [LANE_W-1:0] head_lane;
  logic [OUT_W-1:0]  conv_lane;

  assign m_valid   = (count_q != 2'd0);
  assign handshake = m_valid && m_ready;
  assign pop       = handshake && (lane_q == LAST_LANE);
  // A full buffer still takes a word when the head is popped on the same edge.
  assign wr_accept = data_en && ((count_q != 2'd2) || pop);

  assign head_word = buf_q[rd_ptr_q];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane_split
      assign head_lanes[gi] = head_word[gi*LANE_W +: LANE_W];
    end
  endgenerate

  always_comb begin
    head_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_q == 4'(k)) head_lane = head_lanes[k];
    end
  end

`ifdef FIR_UNPACK_SAT_EN
  localparam int HI_W = LANE_W - OUT_W + 1;
  logic [HI_W-1:0] hi_bits;
  assign hi_bits = head_lane[LANE_W-1:OUT_W-1];

  // In range exactly when every bit above the output sign bit matches it.
  always_comb begin
    if ((hi_bits == {HI_W{1'b0}}) || (hi_bits == {HI_W{1'b1}}))
      conv_lane = head_lane[OUT_W-1:0];
    else if (head_lane[LANE_W-1])
      conv_lane = {1'b1, {(OUT_W-1){1'b0}}};
    else
      conv_lane = {1'b0, {(OUT_W-1){1'b1}}};
  end
`else
  assign conv_lane = head_lane[OUT_W-1:0];
  generate
    if (LANE_W > OUT_W) begin : g_trunc_hi
      logic unused_hi_bits;
      assign unused_hi_bits = ^head_lane[LANE_W-1:OUT_W];
    end
  endgenerate
`endif

  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      always_comb begin
        buf_d[gi] = buf_q[gi];
        if (wr_accept && (wr_ptr_q == 1'(gi))) buf_d[gi] = data_in;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) buf_q[gi] <= '0;
        else     buf_q[gi] <= buf_d[gi];
      end
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lane_d   = lane_q;
    drop_d   = data_en && !wr_accept;

    if (wr_accept) wr_ptr_d = ~wr_ptr_q;
    if (pop)       rd_ptr_d = ~rd_ptr_q;

    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (handshake) lane_d = pop ? 4'd0 : lane_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      lane_q   <= 4'd0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
      drop_q   <= drop_d;
    end
  end

  assign m_data  = m_valid ? conv_lane : '0;
  assign m_lane  = lane_q;
  assign m_last  = m_valid && (lane_q == LAST_LANE);
  assign in_drop = drop_q;
  assign busy    = m_valid;

endmodule

// File: tb/tb_fir_out_unpacker.sv
// Self-checking bench for fir_out_unpacker: directed scenarios plus random
// traffic compared against a word-queue reference model.
module tb_fir_out_unpacker;

  localparam int LANES  = 10;
  localparam int LANE_W = 24;
  localparam int OUT_W  = 16;
  localparam int W      = LANES * LANE_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     data_in;
  logic             data_en;
  logic [OUT_W-1:0] m_data;
  logic [3:0]       m_lane;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             in_drop;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: accepted words in arrival order, lane position in the head word.
  logic [W-1:0] exp_q[$];
  int           exp_lane = 0;
  logic         exp_drop = 1'b0;

  fir_out_unpacker #(.LANES(LANES), .LANE_W(LANE_W), .OUT_W(OUT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .data_en (data_en),
    .m_data  (m_data),
    .m_lane  (m_lane),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .in_drop (in_drop),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_conv(input logic [W-1:0] w, input int k);
    logic [LANE_W-1:0] raw;
    longint v;
    longint max_v;
    longint min_v;
    raw   = w[k*LANE_W +: LANE_W];
    v     = longint'($signed(raw));
    max_v = (64'sd1 <<< (OUT_W - 1)) - 1;
    min_v = -(64'sd1 <<< (OUT_W - 1));
`ifdef FIR_UNPACK_SAT_EN
    if (v > max_v) v = max_v;
    if (v < min_v) v = min_v;
`endif
    return 32'(v & ((64'sd1 <<< OUT_W) - 1));
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    logic [LANE_W-1:0] lv;
    for (int k = 0; k < LANES; k++) begin
      if ($urandom_range(0, 2) == 0)
        lv = LANE_W'($signed(14'($urandom)));
      else
        lv = LANE_W'($urandom);
      w[k*LANE_W +: LANE_W] = lv;
    end
    return w;
  endfunction

  function automatic logic [W-1:0] ramp_word();
    logic [W-1:0] w;
    for (int k = 0; k < LANES; k++) w[k*LANE_W +: LANE_W] = LANE_W'(k * 3);
    return w;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic en, input logic [W-1:0] word, input logic rdy);
    bit hs;
    bit pop;
    bit acc;
    @(negedge clk);
    data_en = en;
    data_in = word;
    m_ready = rdy;
    #1;
    check("valid", m_valid, exp_q.size() > 0);
    check("busy", busy, exp_q.size() > 0);
    check("in_drop", in_drop, exp_drop);
    if (exp_q.size() > 0) begin
      check("data", m_data, exp_conv(exp_q[0], exp_lane));
      check("lane", m_lane, exp_lane);
      check("last", m_last, exp_lane == LANES - 1);
    end else begin
      check("last_idle", m_last, 0);
    end
    hs  = rdy && (exp_q.size() > 0);
    pop = hs && (exp_lane == LANES - 1);
    acc = en && ((exp_q.size() < 2) || pop);
    exp_drop = en && !acc;
    if (hs) begin
      $display("[TB] xfer lane=%0d data=%04h last=%0d", m_lane, m_data, m_last);
      if (pop) begin
        void'(exp_q.pop_front());
        exp_lane = 0;
      end else begin
        exp_lane++;
      end
    end
    if (acc) exp_q.push_back(word);
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
  endtask

  initial begin
    logic [W-1:0] sw;
    logic [31:0]  sat_a;
    logic [31:0]  sat_b;

    rst     = 1'b1;
    data_en = 1'b0;
    data_in = '0;
    m_ready = 1'b0;
    #12;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_lane", m_lane, 0);
    check("rst_last", m_last, 0);
    check("rst_drop", in_drop, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp word streamed with ready held high.
    step(1'b1, ramp_word(), 1'b1);
    idle(12, 1'b1);

    // Three back-to-back strobes with the consumer stalled: third is dropped.
    step(1'b1, rand_word(), 1'b0);
    step(1'b1, rand_word(), 1'b0);
    step(1'b1, rand_word(), 1'b0);
    step(1'b0, '0, 1'b0);
    check("drop_busy", busy, 1);
    idle(22, 1'b1);

    // Full buffer with a strobe on the final-lane handshake.
    step(1'b1, rand_word(), 1'b0);
    step(1'b1, rand_word(), 1'b0);
    idle(9, 1'b1);
    step(1'b1, rand_word(), 1'b1);
    idle(25, 1'b1);

    // Conversion corner values.
    sw = rand_word();
    sw[0*LANE_W +: LANE_W] = 24'h00A000;
    sw[1*LANE_W +: LANE_W] = 24'hFF0000;
`ifdef FIR_UNPACK_SAT_EN
    sat_a = 32'h7FFF;
    sat_b = 32'h8000;
`else
    sat_a = 32'hA000;
    sat_b = 32'h0000;
`endif
    step(1'b1, sw, 1'b0);
    #1;
    check("conv_a", m_data, sat_a);
    step(1'b0, '0, 1'b1);
    #1;
    check("conv_b", m_data, sat_b);
    idle(10, 1'b1);

    // Ready toggling every cycle.
    step(1'b1, rand_word(), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, (i % 2) == 0);
    #1;
    check("toggle_done", busy, 0);

    // Asynchronous reset while streaming lane 4 with a second word buffered.
    step(1'b1, rand_word(), 1'b0);
    step(1'b1, rand_word(), 1'b0);
    idle(4, 1'b1);
    @(negedge clk);
    m_ready = 1'b0;
    check("pre_rst_lane", m_lane, 4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_data", m_data, 0);
    check("arst_lane", m_lane, 0);
    check("arst_busy", busy, 0);
    check("arst_drop", in_drop, 0);
    exp_q.delete();
    exp_lane = 0;
    exp_drop = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    idle(5, 1'b1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      bit en;
      bit rdy;
      en  = (i % 200 < 40) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      step(en, rand_word(), rdy);
    end
    idle(30, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
